// File: rtl/vdp_super_vram_arbiter.sv
// Slot-based arbiter for the shared 32-bit VRAM port in super modes. It serves the display, the command engine, the CPU and a per-line refresh.
// Optional macro SUPER_ARB_CPU_PRIORITY_EN gives CPU strict priority over CMD instead of round-robin.
module vdp_super_vram_arbiter #(
  parameter int REFRESH_CX = 721
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_super,
  input  logic [9:0]  cx,
  input  logic        super_res_drawing,
  input  logic [17:0] super_res_vram_addr,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [19:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        cmd_ack,
  output logic [7:0]  cmd_rdata,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_refresh,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {OWN_NONE, OWN_DISP, OWN_CMD, OWN_CPU, OWN_REF} owner_t;

  owner_t      owner_reg, owner_next;
  logic        last_grant_reg, last_grant_next;  // 1: CPU was served last
  logic        req_wr_reg, req_wr_next;
  logic [1:0]  req_lane_reg, req_lane_next;
  logic        mem_rd_next, mem_wr_next, mem_refresh_next;
  logic [17:0] mem_addr_next;
  logic [3:0]  mem_be_next;
  logic [31:0] mem_wdata_next;
  logic        cmd_ack_next, cpu_ack_next;
  logic [7:0]  cmd_rdata_next, cpu_rdata_next;
  logic        refresh_hit, cmd_wins, grant_any, sel_wr;
  logic [19:0] sel_addr;
  logic [7:0]  sel_wdata, lane_byte;

  // Registered strobes are computed in the phase-0 cycle so they appear in the phase-1 cycle.
  assign refresh_hit = ((cx + 10'd1) == REFRESH_CX[9:0]);
  assign lane_byte   = mem_rdata[{req_lane_reg, 3'b000} +: 8];

`ifdef SUPER_ARB_CPU_PRIORITY_EN
  assign cmd_wins = cmd_req && !cpu_req;
`else
  assign cmd_wins = cmd_req && (!cpu_req || last_grant_reg);
`endif

  assign grant_any = cmd_req || cpu_req;
  assign sel_wr    = cmd_wins ? cmd_wr    : cpu_wr;
  assign sel_addr  = cmd_wins ? cmd_addr  : cpu_addr;
  assign sel_wdata = cmd_wins ? cmd_wdata : cpu_wdata;

  always_comb begin
    owner_next       = owner_reg;
    last_grant_next  = last_grant_reg;
    req_wr_next      = req_wr_reg;
    req_lane_next    = req_lane_reg;
    mem_rd_next      = 1'b0;
    mem_wr_next      = 1'b0;
    mem_refresh_next = 1'b0;
    mem_addr_next    = 18'd0;
    mem_be_next      = 4'd0;
    mem_wdata_next   = 32'd0;
    cmd_ack_next     = 1'b0;
    cpu_ack_next     = 1'b0;
    cmd_rdata_next   = cmd_rdata;
    cpu_rdata_next   = cpu_rdata;
    if (!vdp_super) begin
      owner_next      = OWN_NONE;
      last_grant_next = 1'b1;
      req_wr_next     = 1'b0;
      req_lane_next   = 2'd0;
      cmd_rdata_next  = 8'd0;
      cpu_rdata_next  = 8'd0;
    end else begin
      case (cx[1:0])
        2'd0: begin
          if (refresh_hit) begin
            owner_next       = OWN_REF;
            mem_refresh_next = 1'b1;
          end else if (super_res_drawing) begin
            owner_next    = OWN_DISP;
            mem_rd_next   = 1'b1;
            mem_addr_next = super_res_vram_addr;
          end else if (grant_any) begin
            owner_next      = cmd_wins ? OWN_CMD : OWN_CPU;
            last_grant_next = !cmd_wins;
            req_wr_next     = sel_wr;
            req_lane_next   = sel_addr[1:0];
            mem_addr_next   = sel_addr[19:2];
            if (sel_wr) begin
              mem_wr_next    = 1'b1;
              mem_be_next    = 4'b0001 << sel_addr[1:0];
              mem_wdata_next = {4{sel_wdata}};
            end else begin
              mem_rd_next = 1'b1;
              mem_be_next = 4'b1111;
            end
          end else begin
            owner_next = OWN_NONE;
          end
        end
        2'd2: begin
          // Ack and read byte are registered so they appear in the phase-3 cycle.
          if (owner_reg == OWN_CMD) begin
            cmd_ack_next = 1'b1;
            if (!req_wr_reg) cmd_rdata_next = lane_byte;
          end
          if (owner_reg == OWN_CPU) begin
            cpu_ack_next = 1'b1;
            if (!req_wr_reg) cpu_rdata_next = lane_byte;
          end
        end
        2'd3: owner_next = OWN_NONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= OWN_NONE;
      last_grant_reg <= 1'b1;
      req_wr_reg     <= 1'b0;
      req_lane_reg   <= 2'd0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_refresh    <= 1'b0;
      mem_addr       <= 18'd0;
      mem_be         <= 4'd0;
      mem_wdata      <= 32'd0;
      cmd_ack        <= 1'b0;
      cpu_ack        <= 1'b0;
      cmd_rdata      <= 8'd0;
      cpu_rdata      <= 8'd0;
    end else begin
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      req_wr_reg     <= req_wr_next;
      req_lane_reg   <= req_lane_next;
      mem_rd         <= mem_rd_next;
      mem_wr         <= mem_wr_next;
      mem_refresh    <= mem_refresh_next;
      mem_addr       <= mem_addr_next;
      mem_be         <= mem_be_next;
      mem_wdata      <= mem_wdata_next;
      cmd_ack        <= cmd_ack_next;
      cpu_ack        <= cpu_ack_next;
      cmd_rdata      <= cmd_rdata_next;
      cpu_rdata      <= cpu_rdata_next;
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed bench for vdp_super_vram_arbiter: reset, display, CPU/CMD access, round-robin, refresh, mid-slot reset.
module tb_vdp_super_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vdp_super;
  logic [9:0]  cx;
  logic        super_res_drawing;
  logic [17:0] super_res_vram_addr;
  logic        cmd_req, cmd_wr, cmd_ack;
  logic [19:0] cmd_addr;
  logic [7:0]  cmd_wdata, cmd_rdata;
  logic        cpu_req, cpu_wr, cpu_ack;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_rd, mem_wr, mem_refresh;
  logic [17:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen;

  vdp_super_vram_arbiter #(.REFRESH_CX(721)) dut (
    .clk(clk), .reset(reset), .vdp_super(vdp_super), .cx(cx),
    .super_res_drawing(super_res_drawing), .super_res_vram_addr(super_res_vram_addr),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cx=%0d)", tag, got, exp, cx);
    end else begin
      $display("ok   %s: %h (cx=%0d)", tag, got, cx);
    end
  endtask

  // Advance one clock; cx then names the cycle whose registered outputs are visible.
  task automatic step();
    @(posedge clk);
    #1;
    cx = cx + 10'd1;
  endtask

  task automatic goto_phase0();
    for (int i = 0; i < 4 && cx[1:0] != 2'd0; i++) step();
  endtask

  initial begin
    reset = 1'b1; vdp_super = 1'b1; cx = 10'd0;
    super_res_drawing = 1'b0; super_res_vram_addr = 18'd0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = 20'd0; cmd_wdata = 8'd0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 20'd0; cpu_wdata = 8'd0;
    mem_rdata = 32'h44332211;
    step(); step();
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_refresh", {31'd0, mem_refresh}, 32'd0);
    check("rst_acks", {30'd0, cmd_ack, cpu_ack}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    goto_phase0();

    // CPU write, byte lane 2
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 20'h00006; cpu_wdata = 8'hA5;
    step();
    check("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    check("wr_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("wr_mem_addr", {14'd0, mem_addr}, 32'd1);
    check("wr_mem_be", {28'd0, mem_be}, 32'h4);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    step();
    check("wr_strobe_drop", {31'd0, mem_wr}, 32'd0);
    check("wr_ack_early", {31'd0, cpu_ack}, 32'd0);
    step();
    check("wr_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    step();
    check("wr_ack_pulse", {31'd0, cpu_ack}, 32'd0);

    // CMD read, byte lane 3
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 20'h00013;
    step();
    check("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("rd_mem_addr", {14'd0, mem_addr}, 32'h4);
    check("rd_mem_be", {28'd0, mem_be}, 32'hF);
    step(); step();
    check("rd_cmd_ack", {31'd0, cmd_ack}, 32'd1);
    check("rd_cmd_rdata", {24'd0, cmd_rdata}, 32'h44);
    check("rd_cpu_ack_idle", {31'd0, cpu_ack}, 32'd0);
    // CMD write: rdata must hold
    cmd_wr = 1'b1; cmd_addr = 20'h00001; cmd_wdata = 8'h5A;
    step(); step();
    check("cw_mem_be", {28'd0, mem_be}, 32'h2);
    step(); step();
    check("cw_cmd_ack", {31'd0, cmd_ack}, 32'd1);
    check("cw_rdata_hold", {24'd0, cmd_rdata}, 32'h44);
    cmd_req = 1'b0;
    step();

    // Both requesters held from reset
    reset = 1'b1;
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 20'h00040;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 20'h00080;
    step();
    reset = 1'b0;
    goto_phase0();
    for (int s = 0; s < 4; s++) begin
      logic exp_cmd;
`ifdef SUPER_ARB_CPU_PRIORITY_EN
      exp_cmd = 1'b0;
`else
      exp_cmd = (s % 2 == 0);
`endif
      step();
      check($sformatf("rr_addr_%0d", s), {14'd0, mem_addr}, exp_cmd ? 32'h10 : 32'h20);
      step(); step();
      check($sformatf("rr_acks_%0d", s), {30'd0, cmd_ack, cpu_ack}, exp_cmd ? 32'h2 : 32'h1);
      step();
    end
    cmd_req = 1'b0; cpu_req = 1'b0;
    step(); step(); step(); step();

    // Display window holds off a CPU read
    cx = 10'd4;
    super_res_drawing = 1'b1; super_res_vram_addr = 18'h00123;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 20'h00200;
    step();
    check("disp_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("disp_mem_addr", {14'd0, mem_addr}, 32'h123);
    ack_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (cpu_ack) ack_seen++;
    end
    check("disp_no_cpu_ack", ack_seen, 0);
    super_res_drawing = 1'b0;
    step();
    check("disp_cpu_addr", {14'd0, mem_addr}, 32'h80);
    step(); step();
    check("disp_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    check("disp_cpu_rdata", {24'd0, cpu_rdata}, 32'h11);
    cpu_req = 1'b0;
    step();

    // Refresh beats display at cx=721; display resumes at 725
    cx = 10'd720;
    super_res_drawing = 1'b1; cpu_req = 1'b1;
    step();
    check("ref_strobe", {29'd0, mem_refresh, mem_rd, mem_wr}, 32'h4);
    step();
    check("ref_drop", {31'd0, mem_refresh}, 32'd0);
    step();
    check("ref_no_ack", {31'd0, cpu_ack}, 32'd0);
    step(); step();
    check("ref_disp_next", {13'd0, mem_rd, mem_addr}, {13'd0, 1'b1, 18'h00123});
    cpu_req = 1'b0; super_res_drawing = 1'b0;
    step(); step(); step();

    // Reset mid-slot with CPU read in flight
    goto_phase0();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 20'h00300;
    step();
    check("mid_issue", {31'd0, mem_rd}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_outputs", {mem_rd, mem_addr, mem_be}, 23'd0);
    cpu_req = 1'b0;
    step();
    reset = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cpu_ack) ack_seen++;
    end
    check("mid_no_ack", ack_seen, 0);

    // vdp_super low keeps the block idle
    goto_phase0();
    vdp_super = 1'b0; cpu_req = 1'b1;
    step();
    check("idle_no_strobe", {29'd0, mem_rd, mem_wr, mem_refresh}, 32'd0);
    step(); step();
    check("idle_no_ack", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0; vdp_super = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
